// File: rtl/rf_writeback.sv
// rf_writeback: register file writer. Merges single-cycle ALU results and
// buffered LSU load results into one registered write port. ALU has strict
// priority. Tracks outstanding loads in a per-register pending scoreboard.
module rf_writeback #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int LQ_DEPTH = 2,
  localparam int CW      = $clog2(LQ_DEPTH) + 1,
  localparam int PW      = $clog2(LQ_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_wdata,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rd,
  input  logic [DW-1:0] lsu_wdata,
  input  logic          ld_issue,
  input  logic [AW-1:0] ld_issue_rd,
  output logic [31:0]   pend,
  output logic [CW-1:0] lq_count,
  output logic          we,
  output logic [AW-1:0] rd,
  output logic [DW-1:0] rd_wdata
);

  // LSU result queue storage and pointers
  logic [AW-1:0] q_rd   [LQ_DEPTH];
  logic [DW-1:0] q_data [LQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          push;
  logic          pop;
  logic          not_empty;
  logic [AW-1:0] head_rd;
  logic [DW-1:0] head_data;
  logic [31:0]   pend_set;
  logic [31:0]   pend_clr;

  // Ready is held low during reset and whenever the queue is full.
  assign lsu_ready = rst_n & (lq_count != CW'(LQ_DEPTH));
  assign push      = lsu_valid & lsu_ready;
  assign not_empty = (lq_count != '0);
  // The queue only drains in cycles the ALU leaves the port free.
  assign pop       = ~alu_valid & not_empty;
  assign head_rd   = q_rd[rd_ptr];
  assign head_data = q_data[rd_ptr];

  // Queue payload write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= lsu_rd;
      q_data[wr_ptr] <= lsu_wdata;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at LQ_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lq_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   lq_count <= lq_count + CW'(1);
        2'b01:   lq_count <= lq_count - CW'(1);
        default: lq_count <= lq_count;
      endcase
    end
  end

  // Per-register set/clear strobes; x0 never becomes pending.
  assign pend_set[0] = 1'b0;
  assign pend_clr[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pend
      assign pend_set[gi] = ld_issue & (ld_issue_rd == AW'(gi));
      assign pend_clr[gi] = pop & (head_rd == AW'(gi));
    end
  endgenerate

  // Scoreboard update; a same-edge set overrides the clear (newer load).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
    end
  end

  // Write port arbitration: ALU first, then queue head, else idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we       <= 1'b0;
      rd       <= '0;
      rd_wdata <= '0;
    end else if (alu_valid) begin
      we       <= (alu_rd != '0);
      rd       <= alu_rd;
      rd_wdata <= alu_wdata;
    end else if (not_empty) begin
      we       <= (head_rd != '0);
      rd       <= head_rd;
      rd_wdata <= head_data;
    end else begin
      we       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Directed testbench for rf_writeback: linear sequence of steps with
// hand-computed expectations checked by immediate assertions.
module tb_rf_writeback;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LQ_DEPTH = 2;
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_wdata;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_wdata;
  logic          ld_issue;
  logic [AW-1:0] ld_issue_rd;
  logic [31:0]   pend;
  logic [CW-1:0] lq_count;
  logic          we;
  logic [AW-1:0] rd;
  logic [DW-1:0] rd_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  rf_writeback #(.DW(DW), .AW(AW), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .pend(pend), .lq_count(lq_count),
    .we(we), .rd(rd), .rd_wdata(rd_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_wdata = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wdata = '0; ld_issue = 1'b0; ld_issue_rd = '0;
    tick(); tick();
    chk("rst_we", we, 0);
    chk("rst_rd", rd, 0);
    chk("rst_wdata", rd_wdata, 0);
    chk("rst_pend", pend, 0);
    chk("rst_count", lq_count, 0);
    chk("rst_ready", lsu_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", lsu_ready, 1);

    // 1: ALU-only write, one-cycle latency
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wdata = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    chk("alu_we", we, 1);
    chk("alu_rd", rd, 5);
    chk("alu_wdata", rd_wdata, 32'hDEADBEEF);
    tick();
    chk("alu_we_off", we, 0);
    chk("alu_rd_hold", rd, 5);
    chk("alu_data_hold", rd_wdata, 32'hDEADBEEF);

    // 2: load path with scoreboard set and clear
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    tick();
    ld_issue = 1'b0;
    chk("ld_pend7", pend, 32'h0000_0080);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wdata = 32'h12345678;
    tick();
    lsu_valid = 1'b0;
    chk("ld_count1", lq_count, 1);
    chk("ld_we_early", we, 0);
    chk("ld_pend_hold", pend, 32'h0000_0080);
    tick();
    chk("ld_we", we, 1);
    chk("ld_rd", rd, 7);
    chk("ld_wdata", rd_wdata, 32'h12345678);
    chk("ld_pend_clr", pend, 0);
    chk("ld_count0", lq_count, 0);

    // 3: contention, ALU holds off the queued load for three cycles
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wdata = 32'h0000_0333;
    tick();
    lsu_valid = 1'b0;
    chk("ct_count", lq_count, 1);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_wdata = 32'h11;
    tick();
    chk("ct_rd1", rd, 1);
    chk("ct_cnt_a", lq_count, 1);
    alu_rd = 5'd2; alu_wdata = 32'h22;
    tick();
    chk("ct_rd2", rd, 2);
    chk("ct_cnt_b", lq_count, 1);
    alu_rd = 5'd4; alu_wdata = 32'h44;
    tick();
    chk("ct_rd4", rd, 4);
    chk("ct_data4", rd_wdata, 32'h44);
    chk("ct_cnt_c", lq_count, 1);
    alu_valid = 1'b0;
    tick();
    chk("ct_rd3", rd, 3);
    chk("ct_data3", rd_wdata, 32'h333);
    chk("ct_we3", we, 1);
    chk("ct_cnt0", lq_count, 0);

    // 4: fill the queue while ALU is busy; third load refused
    alu_valid = 1'b1; alu_rd = 5'd10; alu_wdata = 32'hA;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_wdata = 32'hB1;
    tick();
    chk("fl_cnt1", lq_count, 1);
    chk("fl_ready1", lsu_ready, 1);
    lsu_rd = 5'd12; lsu_wdata = 32'hB2;
    tick();
    chk("fl_cnt2", lq_count, 2);
    chk("fl_ready0", lsu_ready, 0);
    lsu_rd = 5'd13; lsu_wdata = 32'hB3;
    tick();
    chk("fl_cnt_full", lq_count, 2);
    chk("fl_alu_rd", rd, 10);
    alu_valid = 1'b0;
    tick();   // pop while full: the waiting third load must not enter
    lsu_valid = 1'b0;
    chk("fl_drain1_rd", rd, 11);
    chk("fl_drain1_d", rd_wdata, 32'hB1);
    chk("fl_drain1_cnt", lq_count, 1);
    chk("fl_ready_back", lsu_ready, 1);
    tick();
    chk("fl_drain2_rd", rd, 12);
    chk("fl_drain2_d", rd_wdata, 32'hB2);
    chk("fl_drain2_cnt", lq_count, 0);
    tick();
    chk("fl_idle_we", we, 0);
    chk("fl_idle_rd", rd, 12);

    // 5: x0 destinations
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wdata = 32'hFF;
    tick();
    alu_valid = 1'b0;
    chk("x0_alu_we", we, 0);
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wdata = 32'h55;
    tick();
    lsu_valid = 1'b0;
    chk("x0_lsu_cnt1", lq_count, 1);
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    tick();
    ld_issue = 1'b0;
    chk("x0_lsu_we", we, 0);
    chk("x0_lsu_cnt0", lq_count, 0);
    chk("x0_pend", pend, 0);

    // 6: set/clear race on x9, then async reset with a full queue
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    tick();
    ld_issue = 1'b0;
    chk("rc_pend9", pend, 32'h0000_0200);
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wdata = 32'h99;
    tick();
    lsu_valid = 1'b0;
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    tick();
    ld_issue = 1'b0;
    chk("rc_we9", rd, 9);
    chk("rc_pend_set", pend, 32'h0000_0200);
    tick();
    chk("rc_pend_keep", pend, 32'h0000_0200);

    alu_valid = 1'b1; alu_rd = 5'd20; alu_wdata = 32'h20;
    lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_wdata = 32'h21;
    ld_issue = 1'b1; ld_issue_rd = 5'd21;
    tick();
    ld_issue = 1'b0;
    lsu_rd = 5'd22; lsu_wdata = 32'h22;
    tick();
    lsu_valid = 1'b0;
    chk("pr_cnt_full", lq_count, 2);
    chk("pr_we", we, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_we", we, 0);
    chk("ar_pend", pend, 0);
    chk("ar_cnt", lq_count, 0);
    chk("ar_ready", lsu_ready, 0);
    alu_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_we", we, 0);
    chk("post_cnt", lq_count, 0);
    chk("post_ready", lsu_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
